lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of the effective address and MemAddr.
REQ-002 Parameter DATA_WIDTH, default 32, data width; only 32 is supported because of the 4-bit byte-enable.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MemReadM  input  1  MEM-stage load request.
REQ-006 MemWriteM  input  1  MEM-stage store request.
REQ-007 LoadSrcM  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 StoreSrcM  input  2  store type: 00 SB, 01 SH, 10 SW.
REQ-009 ALUResultM  input  ADDR_WIDTH  effective byte address.
REQ-010 WriteDataM  input  DATA_WIDTH  store data, right-aligned.
REQ-011 FlushM  input  1  pipeline flush of the MEM stage.
REQ-012 MemReq  output  1  memory request valid.
REQ-013 MemWe  output  1  request is a write.
REQ-014 MemAddr  output  ADDR_WIDTH  word-aligned address, bits [1:0] = 0.
REQ-015 MemWData  output  DATA_WIDTH  lane-replicated store data.
REQ-016 MemBe  output  4  byte enables.
REQ-017 MemGnt  input  1  memory accepts the request this cycle.
REQ-018 MemRValid  input  1  read data valid.
REQ-019 MemRData  input  DATA_WIDTH  read word.
REQ-020 ReadPartDataM  output  DATA_WIDTH  registered, aligned and extended load result.
REQ-021 LsuStall  output  1  hold the pipeline.
REQ-022 MisalignM  output  1  combinational misaligned-access flag.

Function
REQ-023 FSM states SHALL be IDLE, REQ, WAIT, DONE.
- IDLE->REQ: (MemReadM|MemWriteM) & ~FlushM & ~misaligned.
- On that edge, latch op, type, address, data and byte-enables.
REQ-024 If both MemReadM and MemWriteM are set, the load SHALL win and the write is ignored.
REQ-025 In REQ, MemReq=1 with stable MemAddr/MemWe/MemWData/MemBe until MemGnt; transitions:
- MemGnt & store -> DONE.
- MemGnt & load -> WAIT.
REQ-026 In WAIT, MemRValid -> DONE, and ReadPartDataM is loaded on that edge; MemRValid outside WAIT SHALL be ignored.
REQ-027 In DONE, LsuStall=0 for exactly one cycle, then unconditionally IDLE; a new access cannot start from DONE.
REQ-028 LsuStall SHALL be:
- 1 in IDLE when an access starts that cycle;
- 1 throughout REQ and WAIT;
- 0 otherwise.
REQ-029 Minimum latency: store 2 stall cycles (IDLE, REQ); load 3 stall cycles (IDLE, REQ, WAIT with RValid); MemRValid is never earlier than the cycle after MemGnt.
REQ-030 Misalignment (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0):
- MisalignM=1 in IDLE only;
- no request issued, no stall.
REQ-031 MemBe:
- SB: 0001<<addr[1:0].
- SH: 0011<<{addr[1],0}.
- SW: 1111.
REQ-032 MemWData:
- SB: byte replicated x4.
- SH: half replicated x2.
- SW: unchanged.
REQ-033 Load result:
- shift MemRData right by 8*addr[1:0];
- LB/LH sign-extend from bit 7/15;
- LBU/LHU zero-extend;
- LW passes unchanged;
- undefined LoadSrcM codes yield 0.
REQ-034 FlushM behaviour:
- In REQ before MemGnt: abort to IDLE, MemReq drops next cycle.
- In WAIT: keep stalling until MemRValid, then go to IDLE without updating ReadPartDataM.
- In DONE: ignored.

Reset
REQ-035 Asynchronous reset SHALL force:
- state IDLE;
- MemReq, MemWe, MemAddr, MemWData, MemBe, ReadPartDataM, LsuStall, MisalignM all 0;
- all latched request fields 0.
REQ-036 Reset mid-access SHALL abandon the transaction; any later MemGnt/MemRValid is ignored while in IDLE.

Structure
REQ-037 Package lsu_pkg SHALL hold:
- the state enum;
- LoadSrc and StoreSrc encodings as named constants;
- the byte-enable width constant.
REQ-038 One sub-module, load_align, SHALL hold the combinational shift and extension of REQ-033; all sequencing stays in lsu_ctrl.

Verification
REQ-039 LB at addr 0x103, MemRData 0x80FF_0000, gnt and rvalid immediate -> ReadPartDataM 0xFFFF_FF80, LsuStall high 3 cycles.
REQ-040 SH at addr 0x202, WriteDataM 0x1234_ABCD -> MemBe 1100, MemWData 0xABCD_ABCD, MemAddr 0x200, stall 2 cycles.
REQ-041 LW at addr 0x006 -> MisalignM 1, MemReq 0, LsuStall 0.
REQ-042 LHU at 0x002, MemGnt delayed 3 cycles, MemRData 0x8001_0000 -> MemReq held 4 cycles, result 0x0000_8001.
REQ-043 Load in REQ with FlushM pulse before MemGnt -> MemReq drops next cycle, state IDLE, ReadPartDataM unchanged.
REQ-044 reset asserted in WAIT, then a stray MemRValid -> all outputs 0, no result captured.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit controller.
package lsu_pkg;

  localparam int unsigned BeWidth = 4;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

  localparam logic [2:0] LoadLb  = 3'b000;
  localparam logic [2:0] LoadLh  = 3'b001;
  localparam logic [2:0] LoadLw  = 3'b010;
  localparam logic [2:0] LoadLbu = 3'b100;
  localparam logic [2:0] LoadLhu = 3'b101;

  localparam logic [1:0] StoreSb = 2'b00;
  localparam logic [1:0] StoreSh = 2'b01;
  localparam logic [1:0] StoreSw = 2'b10;

  // Access size shares the store encoding; loads use LoadSrc[1:0].
  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  function automatic logic [BeWidth-1:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [BeWidth-1:0] be;
    case (size)
      SizeByte: be = 4'b0001 << off;
      SizeHalf: be = 4'b0011 << {off[1], 1'b0};
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SizeHalf) && off[0]) || ((size == SizeWord) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_align.sv
// Shifts the returned word down to the accessed byte lane and extends it to full width.
module load_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            offset,
  input  logic [2:0]            load_src,
  output logic [DATA_WIDTH-1:0] result
);

  logic [DATA_WIDTH-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    result = '0;
    case (load_src)
      LoadLb:  result = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      LoadLh:  result = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      LoadLw:  result = shifted;
      LoadLbu: result = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      LoadLhu: result = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: issues one memory request per access and stalls the
// pipeline until it completes; load data is aligned and registered on return.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            LoadSrcM,
  input  logic [1:0]            StoreSrcM,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic                  FlushM,
  output logic                  MemReq,
  output logic                  MemWe,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWData,
  output logic [BeWidth-1:0]    MemBe,
  input  logic                  MemGnt,
  input  logic                  MemRValid,
  input  logic [DATA_WIDTH-1:0] MemRData,
  output logic [DATA_WIDTH-1:0] ReadPartDataM,
  output logic                  LsuStall,
  output logic                  MisalignM
);

  lsu_state_e state_q, state_d;

  logic                  load_q;
  logic [2:0]            lsrc_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BeWidth-1:0]    be_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  flushed_q, flushed_d;

  logic                  access;
  logic [1:0]            size;
  logic                  misaligned;
  logic                  start;
  logic                  capture;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic [DATA_WIDTH-1:0] aligned;

  // A simultaneous read and write is treated as a load.
  assign access     = MemReadM | MemWriteM;
  assign size       = MemReadM ? LoadSrcM[1:0] : StoreSrcM;
  assign misaligned = is_misaligned(size, ALUResultM[1:0]);
  assign start      = (state_q == IDLE) && access && !FlushM && !misaligned;
  assign capture    = (state_q == WAIT) && MemRValid && !flushed_q && !FlushM;

  always_comb begin
    case (StoreSrcM)
      StoreSb: wdata_rep = {(DATA_WIDTH/8){WriteDataM[7:0]}};
      StoreSh: wdata_rep = {(DATA_WIDTH/16){WriteDataM[15:0]}};
      default: wdata_rep = WriteDataM;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    flushed_d = flushed_q;
    unique case (state_q)
      IDLE: begin
        flushed_d = 1'b0;
        if (start) state_d = REQ;
      end
      REQ: begin
        // A flush coinciding with the grant cannot retract the request; it only drops the data.
        if (MemGnt) begin
          state_d   = load_q ? WAIT : DONE;
          flushed_d = FlushM;
        end else if (FlushM) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (FlushM) flushed_d = 1'b1;
        if (MemRValid) state_d = (flushed_q || FlushM) ? IDLE : DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      flushed_q <= 1'b0;
      load_q    <= 1'b0;
      lsrc_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      flushed_q <= flushed_d;
      if (start) begin
        load_q  <= MemReadM;
        lsrc_q  <= LoadSrcM;
        addr_q  <= ALUResultM;
        wdata_q <= MemReadM ? '0 : wdata_rep;
        be_q    <= byte_en(size, ALUResultM[1:0]);
      end
      if (capture) rdata_q <= aligned;
    end
  end

  load_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_align (
    .rdata   (MemRData),
    .offset  (addr_q[1:0]),
    .load_src(lsrc_q),
    .result  (aligned)
  );

  assign MemReq        = (state_q == REQ);
  assign MemWe         = MemReq && !load_q;
  assign MemAddr       = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign MemWData      = wdata_q;
  assign MemBe         = be_q;
  assign ReadPartDataM = rdata_q;
  assign LsuStall      = start || (state_q == REQ) || (state_q == WAIT);
  assign MisalignM     = (state_q == IDLE) && access && misaligned;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: table of single accesses plus flush and reset sequences.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM, FlushM;
  logic [2:0]  LoadSrcM;
  logic [1:0]  StoreSrcM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        MemReq, MemWe, MemGnt, MemRValid, LsuStall, MisalignM;
  logic [31:0] MemAddr, MemWData, MemRData, ReadPartDataM;
  logic [3:0]  MemBe;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res = 32'h0;

  always #5 clk = ~clk;

  lsu_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .MemReadM     (MemReadM),
    .MemWriteM    (MemWriteM),
    .LoadSrcM     (LoadSrcM),
    .StoreSrcM    (StoreSrcM),
    .ALUResultM   (ALUResultM),
    .WriteDataM   (WriteDataM),
    .FlushM       (FlushM),
    .MemReq       (MemReq),
    .MemWe        (MemWe),
    .MemAddr      (MemAddr),
    .MemWData     (MemWData),
    .MemBe        (MemBe),
    .MemGnt       (MemGnt),
    .MemRValid    (MemRValid),
    .MemRData     (MemRData),
    .ReadPartDataM(ReadPartDataM),
    .LsuStall     (LsuStall),
    .MisalignM    (MisalignM)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  lsrc;
    logic [1:0]  ssrc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gd;
    int          rvd;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   stall_n = 0;
    int   req_n = 0;
    int   wait_n = 0;
    logic granted = 1'b0;
    logic seen_req = 1'b0;
    logic done = 1'b0;
    logic [31:0] addr_s = 32'h0;
    logic [31:0] wd_s = 32'h0;
    logic [3:0]  be_s = 4'h0;
    logic        we_s = 1'b0;
    logic        undef_ld;
    undef_ld = v.rd && (v.lsrc inside {3'b011, 3'b110, 3'b111});
    @(posedge clk); #1;
    MemReadM = v.rd; MemWriteM = v.wr; LoadSrcM = v.lsrc; StoreSrcM = v.ssrc;
    ALUResultM = v.addr; WriteDataM = v.wdata; MemRData = v.rdata;
    @(negedge clk);
    chk($sformatf("v%0d misalign", idx), {31'b0, MisalignM}, {31'b0, v.mis});
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (LsuStall) stall_n++;
      if (granted && v.rd) begin
        wait_n++;
        MemRValid = (wait_n > v.rvd);
      end
      if (MemReq) begin
        req_n++;
        if (!seen_req) begin
          addr_s = MemAddr; be_s = MemBe; wd_s = MemWData; we_s = MemWe;
        end
        seen_req = 1'b1;
        MemGnt = (req_n > v.gd);
        if (MemGnt) granted = 1'b1;
      end else begin
        MemGnt = 1'b0;
      end
      if (!LsuStall) done = 1'b1;
      else begin
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
      end
    end
    MemGnt = 1'b0; MemRValid = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL v%0d timeout: got stall still high expected completion", idx);
    end
    if (v.mis) begin
      chk($sformatf("v%0d stalls", idx), stall_n, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("v%0d noreq", idx), {31'b0, MemReq}, 32'h0);
    end else begin
      chk($sformatf("v%0d stalls", idx), stall_n, v.rd ? 3 + v.gd + v.rvd : 2 + v.gd);
      chk($sformatf("v%0d req_cycles", idx), req_n, 1 + v.gd);
      chk($sformatf("v%0d addr", idx), addr_s, v.addr & 32'hFFFF_FFFC);
      if (!undef_ld) chk($sformatf("v%0d be", idx), {28'b0, be_s}, {28'b0, v.be});
      chk($sformatf("v%0d we", idx), {31'b0, we_s}, {31'b0, v.wr && !v.rd});
      if (!v.rd) chk($sformatf("v%0d wdata", idx), wd_s, v.wd);
      else last_res = v.res;
    end
    chk($sformatf("v%0d result", idx), ReadPartDataM, last_res);
  endtask

  task automatic start_load(input logic [31:0] addr, input logic [31:0] rdata);
    @(posedge clk); #1;
    MemReadM = 1'b1; LoadSrcM = 3'b010; ALUResultM = addr; MemRData = rdata;
    @(negedge clk);
    @(posedge clk); #1;
    MemReadM = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    MemReadM = 0; MemWriteM = 0; FlushM = 0; LoadSrcM = 0; StoreSrcM = 0;
    ALUResultM = 0; WriteDataM = 0; MemGnt = 0; MemRValid = 0; MemRData = 0;

    //                rd wr lsrc    ssrc   addr     wdata         rdata         gd rvd mis be       wd            res
    vecs[0]  = '{1, 0, 3'b000, 2'b00, 32'h103, 32'h0,        32'h80FF_0000, 0, 0, 0, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{0, 1, 3'b000, 2'b01, 32'h202, 32'h1234_ABCD, 32'h0,        0, 0, 0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[2]  = '{1, 0, 3'b010, 2'b00, 32'h006, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0};
    vecs[3]  = '{1, 0, 3'b101, 2'b00, 32'h002, 32'h0,        32'h8001_0000, 3, 0, 0, 4'b1100, 32'h0,        32'h0000_8001};
    vecs[4]  = '{0, 1, 3'b000, 2'b00, 32'h011, 32'h0000_00A5, 32'h0,        0, 0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[5]  = '{0, 1, 3'b000, 2'b10, 32'h020, 32'hDEAD_BEEF, 32'h0,        1, 0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[6]  = '{1, 0, 3'b001, 2'b00, 32'h001, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0};
    vecs[7]  = '{1, 0, 3'b100, 2'b00, 32'h101, 32'h0,        32'h0000_C300, 0, 0, 0, 4'b0010, 32'h0,        32'h0000_00C3};
    vecs[8]  = '{1, 0, 3'b001, 2'b00, 32'h040, 32'h0,        32'h1234_F00D, 0, 2, 0, 4'b0011, 32'h0,        32'hFFFF_F00D};
    vecs[9]  = '{1, 0, 3'b010, 2'b00, 32'h044, 32'h0,        32'hCAFE_BABE, 0, 0, 0, 4'b1111, 32'h0,        32'hCAFE_BABE};
    vecs[10] = '{1, 0, 3'b111, 2'b00, 32'h048, 32'h0,        32'h1234_5678, 0, 0, 0, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{1, 1, 3'b000, 2'b10, 32'h003, 32'h5555_5555, 32'h7F00_0000, 0, 0, 0, 4'b1000, 32'h0,        32'h0000_007F};
    vecs[12] = '{0, 1, 3'b000, 2'b10, 32'h022, 32'h1111_1111, 32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0};

    @(negedge clk);
    chk("rst MemReq", {31'b0, MemReq}, 32'h0);
    chk("rst LsuStall", {31'b0, LsuStall}, 32'h0);
    chk("rst outputs", MemAddr | MemWData | ReadPartDataM | {28'b0, MemBe} | {31'b0, MemWe}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Flush in IDLE suppresses the access entirely.
    @(posedge clk); #1;
    MemReadM = 1'b1; LoadSrcM = 3'b010; ALUResultM = 32'h0B0; FlushM = 1'b1;
    @(negedge clk);
    chk("idle flush stall", {31'b0, LsuStall}, 32'h0);
    @(posedge clk); #1;
    MemReadM = 1'b0; FlushM = 1'b0;
    @(negedge clk);
    chk("idle flush noreq", {31'b0, MemReq}, 32'h0);

    // Flush while REQ is still waiting for the grant.
    start_load(32'h0C0, 32'h9999_9999);
    @(negedge clk);
    chk("req flush req_before", {31'b0, MemReq}, 32'h1);
    FlushM = 1'b1;
    @(posedge clk); #1;
    FlushM = 1'b0;
    @(negedge clk);
    chk("req flush req_after", {31'b0, MemReq}, 32'h0);
    chk("req flush stall", {31'b0, LsuStall}, 32'h0);
    chk("req flush result", ReadPartDataM, last_res);

    // Flush in WAIT: keep stalling until data returns, then discard it.
    start_load(32'h0D0, 32'h1111_2222);
    @(negedge clk);
    MemGnt = 1'b1;
    @(posedge clk); #1;
    MemGnt = 1'b0;
    @(negedge clk);
    FlushM = 1'b1;
    chk("wait flush stall0", {31'b0, LsuStall}, 32'h1);
    @(posedge clk); #1;
    FlushM = 1'b0;
    @(negedge clk);
    chk("wait flush stall1", {31'b0, LsuStall}, 32'h1);
    MemRValid = 1'b1;
    @(posedge clk); #1;
    MemRValid = 1'b0;
    @(negedge clk);
    chk("wait flush stall2", {31'b0, LsuStall}, 32'h0);
    chk("wait flush result", ReadPartDataM, last_res);

    // Stray RValid while idle is ignored.
    MemRValid = 1'b1; MemRData = 32'h7777_7777;
    @(posedge clk); #1;
    MemRValid = 1'b0;
    @(negedge clk);
    chk("idle rvalid result", ReadPartDataM, last_res);

    // Reset in WAIT, then a late RValid.
    start_load(32'h0E0, 32'hABAB_ABAB);
    @(negedge clk);
    MemGnt = 1'b1;
    @(posedge clk); #1;
    MemGnt = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("wait rst stall", {31'b0, LsuStall}, 32'h0);
    chk("wait rst outputs", MemAddr | MemWData | ReadPartDataM | {28'b0, MemBe} |
        {30'b0, MemReq, MemWe}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_res = 32'h0;
    @(negedge clk);
    MemRValid = 1'b1; MemRData = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    MemRValid = 1'b0;
    @(negedge clk);
    chk("post rst result", ReadPartDataM, last_res);
    chk("post rst stall", {31'b0, LsuStall}, 32'h0);
    chk("post rst req", {31'b0, MemReq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
